// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: FSM state encoding and width helpers shared by the adder arbiter files. Rev 1.0
`default_nettype none

package adder_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } t_arb_state;

   // Index width that stays at least one bit wide for degenerate counts.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ripplecarryadder.sv
// ripplecarryadder: BITS-wide ripple-carry adder, modulo 2^BITS, carry-out discarded. Rev 1.0
`default_nettype none

module ripplecarryadder #(
   parameter int BITS = 16
) (
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   output logic [BITS-1:0] sum
);

   logic [BITS-1:0] carry;

   assign carry[0] = 1'b0;

   generate
      for (genvar i = 0; i < BITS; i++) begin : g_bit
         assign sum[i] = a[i] ^ b[i] ^ carry[i];
         if (i < BITS - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
         end
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick, first request above ptr with wrap-around. Rev 1.0
`default_nettype none

module rr_picker
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] winner_oh,
   output logic [IW-1:0]      winner_idx,
   output logic               found
);

   logic [IW-1:0] pos;

   // Walking ptr+1 .. ptr+NUM_REQ is the rotate / encode / rotate-back in one pass.
   always_comb begin
      winner_oh  = '0;
      winner_idx = '0;
      found      = 1'b0;
      pos        = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         pos = IW'((int'(ptr) + i) % NUM_REQ);
         if (!found && req[pos]) begin
            found          = 1'b1;
            winner_oh[pos] = 1'b1;
            winner_idx     = pos;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one multicycle ripple-carry adder among NUM_REQ clients.
// Optional signed-overflow flag out_ovf when ADDER_ARB_OVERFLOW_EN is defined. Rev 1.0
`default_nettype none

module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int BITS          = 16,
   parameter int NUM_REQ       = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                    in_clk,
   input  logic                    in_rst_n,
   input  logic [NUM_REQ-1:0]      in_req,
   input  logic [NUM_REQ*BITS-1:0] in_a,
   input  logic [NUM_REQ*BITS-1:0] in_b,
   output logic [NUM_REQ-1:0]      out_grant,
   output logic [NUM_REQ-1:0]      out_ack,
   output logic [BITS-1:0]         out_sum,
`ifdef ADDER_ARB_OVERFLOW_EN
   output logic                    out_ovf,
`endif
   output logic                    out_busy
);

   localparam int IW = idx_width(NUM_REQ);
   localparam int CW = idx_width(SETTLE_CYCLES);

   t_arb_state          state, state_nxt;
   logic [CW-1:0]       cnt;
   logic [IW-1:0]       ptr;
   logic [IW-1:0]       win_idx;
   logic [BITS-1:0]     op_a, op_b;
   logic [BITS-1:0]     adder_sum;
   logic [NUM_REQ-1:0]  pick_oh;
   logic [IW-1:0]       pick_idx;
   logic                pick_found;

   rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
      .req        (in_req),
      .ptr        (ptr),
      .winner_oh  (pick_oh),
      .winner_idx (pick_idx),
      .found      (pick_found)
   );

   // Only the operand registers feed the adder, so its path may span SETTLE_CYCLES.
   ripplecarryadder #(.BITS(BITS)) u_adder (
      .a   (op_a),
      .b   (op_b),
      .sum (adder_sum)
   );

   always_ff @(posedge in_clk) begin
      if (!in_rst_n) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_found) state_nxt = SETTLE;
         SETTLE:  if (cnt == CW'(SETTLE_CYCLES - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign out_busy = (state != IDLE);

   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         cnt       <= '0;
         ptr       <= IW'(NUM_REQ - 1);
         win_idx   <= '0;
         op_a      <= '0;
         op_b      <= '0;
         out_grant <= '0;
         out_ack   <= '0;
         out_sum   <= '0;
`ifdef ADDER_ARB_OVERFLOW_EN
         out_ovf   <= 1'b0;
`endif
      end else begin
         out_ack <= '0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  op_a      <= in_a[pick_idx*BITS +: BITS];
                  op_b      <= in_b[pick_idx*BITS +: BITS];
                  out_grant <= pick_oh;
                  win_idx   <= pick_idx;
                  cnt       <= '0;
               end
            end
            SETTLE: cnt <= cnt + CW'(1);
            DONE: begin
               out_sum   <= adder_sum;
               out_ack   <= out_grant;
               out_grant <= '0;
               ptr       <= win_idx;
`ifdef ADDER_ARB_OVERFLOW_EN
               out_ovf   <= (op_a[BITS-1] == op_b[BITS-1]) &&
                            (adder_sum[BITS-1] != op_a[BITS-1]);
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
